// File: rtl/clk_div_sched_if.sv
// Ratio-change handshake between a requester and clk_div_sched.
// The requester holds div_req/div_val until it sees div_ack.
interface clk_div_sched_if #(
  parameter int W = 8
);
  logic         div_req;
  logic [W-1:0] div_val;
  logic         div_ack;
  logic         div_err;

  modport master (output div_req, output div_val, input div_ack, input div_err);
  modport slave  (input div_req, input div_val, output div_ack, output div_err);
endinterface

// File: rtl/clk_div_sched.sv
// Runtime-programmable clock divider. Ratio changes and stops only take
// effect at period boundaries, so the divided clock never has a runt pulse.
module clk_div_sched #(
  parameter int W       = 8,
  parameter int DEF_DIV = 2
) (
  input  logic          in,
  input  logic          resetn,
  input  logic          en,
  clk_div_sched_if.slave bus,
  output logic          out,
  output logic          tick,
  output logic          running,
  output logic [W-1:0]  cur_div
);

  typedef enum logic {STOP, RUN} state_t;

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] pend_val;
  logic         pend;

  logic         req_take;
  logic         req_bad;
  logic         at_end;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] half_hi;

  // A request is only sampled when nothing is outstanding and we are not
  // in the ack cycle of the previous one (requester may still hold div_req).
  assign req_take = bus.div_req && !pend && !bus.div_ack;
  assign req_bad  = bus.div_val < TWO;
  assign at_end   = (cnt == cur_div - ONE);
  assign cnt_inc  = cnt + ONE;
  assign half_hi  = cur_div - (cur_div >> 1);

  always_ff @(posedge in or negedge resetn) begin
    if (!resetn) begin
      state       <= STOP;
      cnt         <= '0;
      pend_val    <= '0;
      pend        <= 1'b0;
      cur_div     <= W'(DEF_DIV);
      out         <= 1'b0;
      tick        <= 1'b0;
      running     <= 1'b0;
      bus.div_ack <= 1'b0;
      bus.div_err <= 1'b0;
    end else begin
      bus.div_ack <= 1'b0;
      bus.div_err <= 1'b0;
      tick        <= 1'b0;

      if (req_take && req_bad) begin
        bus.div_ack <= 1'b1;
        bus.div_err <= 1'b1;
      end

      case (state)
        STOP: begin
          // A ratio accepted in the same cycle as en rises governs the first period.
          if (req_take && !req_bad) begin
            cur_div     <= bus.div_val;
            bus.div_ack <= 1'b1;
          end
          if (en) begin
            state   <= RUN;
            running <= 1'b1;
            out     <= 1'b1;
            tick    <= 1'b1;
            cnt     <= '0;
          end
        end

        RUN: begin
          if (at_end) begin
            cnt <= '0;
            if (pend) begin
              cur_div     <= pend_val;
              pend        <= 1'b0;
              bus.div_ack <= 1'b1;
            end
            if (en) begin
              out  <= 1'b1;
              tick <= 1'b1;
            end else begin
              state   <= STOP;
              running <= 1'b0;
              out     <= 1'b0;
            end
          end else begin
            cnt <= cnt_inc;
            out <= (cnt_inc < half_hi);
          end
          // Latched at the boundary itself means it waits for the next one.
          if (req_take && !req_bad) begin
            pend_val <= bus.div_val;
            pend     <= 1'b1;
          end
        end

        default: state <= STOP;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: a vector table for steady-state behaviour
// plus hand-written sequences for stop, simultaneous events and async reset.
module tb_clk_div_sched;

  typedef struct {
    logic       en;
    logic       req;
    logic [7:0] val;
    logic       o;
    logic       t;
    logic       r;
    logic       a;
    logic       e;
    logic [7:0] cd;
  } vec_t;

  logic       in = 1'b0;
  logic       resetn;
  logic       en;
  logic       out;
  logic       tick;
  logic       running;
  logic [7:0] cur_div;

  int n_checks = 0;
  int n_fails  = 0;

  vec_t vecs[$];

  clk_div_sched_if #(.W(8)) bus ();

  clk_div_sched #(.W(8), .DEF_DIV(2)) dut (
    .in      (in),
    .resetn  (resetn),
    .en      (en),
    .bus     (bus),
    .out     (out),
    .tick    (tick),
    .running (running),
    .cur_div (cur_div)
  );

  always #5 in = ~in;

  function automatic vec_t mk(input logic v_en, input logic v_req, input int v_val,
                              input logic v_o, input logic v_t, input logic v_r,
                              input logic v_a, input logic v_e, input int v_cd);
    vec_t v;
    v.en  = v_en;
    v.req = v_req;
    v.val = 8'(v_val);
    v.o   = v_o;
    v.t   = v_t;
    v.r   = v_r;
    v.a   = v_a;
    v.e   = v_e;
    v.cd  = 8'(v_cd);
    return v;
  endfunction

  task automatic checkField(input string name, input string field,
                            input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s.%s got %0d expected %0d", name, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic o, input logic t,
                             input logic r, input logic a, input logic e,
                             input logic [7:0] cd);
    checkField(name, "out",     {7'd0, out},         {7'd0, o});
    checkField(name, "tick",    {7'd0, tick},        {7'd0, t});
    checkField(name, "running", {7'd0, running},     {7'd0, r});
    checkField(name, "div_ack", {7'd0, bus.div_ack}, {7'd0, a});
    checkField(name, "div_err", {7'd0, bus.div_err}, {7'd0, e});
    checkField(name, "cur_div", cur_div,             cd);
  endtask

  // Inputs change at the falling edge; outputs are read one falling edge later.
  task automatic applyStimulus(input logic s_en, input logic s_req, input int s_val);
    en          = s_en;
    bus.div_req = s_req;
    bus.div_val = 8'(s_val);
    @(posedge in);
    @(negedge in);
  endtask

  task automatic stepCheck(input string name, input logic s_en, input logic s_req,
                           input int s_val, input logic o, input logic t,
                           input logic r, input logic a, input logic e, input int cd);
    applyStimulus(s_en, s_req, s_val);
    checkOutput(name, o, t, r, a, e, 8'(cd));
  endtask

  initial begin
    resetn      = 1'b0;
    en          = 1'b0;
    bus.div_req = 1'b0;
    bus.div_val = 8'd0;

    // N=2 free run, then stop at the period end
    vecs.push_back(mk(1,0,0, 1,1,1,0,0,2));
    vecs.push_back(mk(1,0,0, 0,0,1,0,0,2));
    vecs.push_back(mk(1,0,0, 1,1,1,0,0,2));
    vecs.push_back(mk(1,0,0, 0,0,1,0,0,2));
    vecs.push_back(mk(0,0,0, 0,0,0,0,0,2));
    vecs.push_back(mk(0,0,0, 0,0,0,0,0,2));
    // ratio 5 set while stopped, then two periods of 3 high / 2 low
    vecs.push_back(mk(0,1,5, 0,0,0,1,0,5));
    vecs.push_back(mk(1,0,0, 1,1,1,0,0,5));
    vecs.push_back(mk(1,0,0, 1,0,1,0,0,5));
    vecs.push_back(mk(1,0,0, 1,0,1,0,0,5));
    vecs.push_back(mk(1,0,0, 0,0,1,0,0,5));
    vecs.push_back(mk(1,0,0, 0,0,1,0,0,5));
    vecs.push_back(mk(1,0,0, 1,1,1,0,0,5));
    // request 4 at c=0, applied at the boundary with ack on the tick
    vecs.push_back(mk(1,1,4, 1,0,1,0,0,5));
    vecs.push_back(mk(1,1,4, 1,0,1,0,0,5));
    vecs.push_back(mk(1,1,4, 0,0,1,0,0,5));
    vecs.push_back(mk(1,1,4, 0,0,1,0,0,5));
    vecs.push_back(mk(1,1,4, 1,1,1,1,0,4));
    vecs.push_back(mk(1,0,0, 1,0,1,0,0,4));
    // N=4, request 3 at c=1: c=2,3 stay low, next period 2 high / 1 low
    vecs.push_back(mk(1,1,3, 0,0,1,0,0,4));
    vecs.push_back(mk(1,1,3, 0,0,1,0,0,4));
    vecs.push_back(mk(1,1,3, 1,1,1,1,0,3));
    vecs.push_back(mk(1,0,0, 1,0,1,0,0,3));
    vecs.push_back(mk(1,0,0, 0,0,1,0,0,3));
    vecs.push_back(mk(1,0,0, 1,1,1,0,0,3));
    // illegal ratios 1 and 0; second one held through its ack cycle
    vecs.push_back(mk(1,1,1, 1,0,1,1,1,3));
    vecs.push_back(mk(1,0,0, 0,0,1,0,0,3));
    vecs.push_back(mk(1,1,0, 1,1,1,1,1,3));
    vecs.push_back(mk(1,1,0, 1,0,1,0,0,3));
    vecs.push_back(mk(1,0,0, 0,0,1,0,0,3));
    // request sampled at c=N-1 waits a full period
    vecs.push_back(mk(1,1,2, 1,1,1,0,0,3));
    vecs.push_back(mk(1,1,2, 1,0,1,0,0,3));
    vecs.push_back(mk(1,1,2, 0,0,1,0,0,3));
    vecs.push_back(mk(1,1,2, 1,1,1,1,0,2));
    vecs.push_back(mk(1,0,0, 0,0,1,0,0,2));

    @(negedge in);
    checkOutput("reset", 0, 0, 0, 0, 0, 8'd2);
    @(negedge in);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].req, vecs[i].val);
      checkOutput($sformatf("vec%0d", i), vecs[i].o, vecs[i].t, vecs[i].r,
                  vecs[i].a, vecs[i].e, vecs[i].cd);
    end

    // switch to N=6 (request lands on a boundary, so applied one period later)
    stepCheck("n6_a", 1,1,6, 1,1,1,0,0,2);
    stepCheck("n6_b", 1,1,6, 0,0,1,0,0,2);
    stepCheck("n6_c", 1,1,6, 1,1,1,1,0,6);
    stepCheck("n6_d", 1,0,0, 1,0,1,0,0,6);
    // en dropped at c=1: period completes, then STOP
    stepCheck("stop_c2", 0,0,0, 1,0,1,0,0,6);
    stepCheck("stop_c3", 0,0,0, 0,0,1,0,0,6);
    stepCheck("stop_c4", 0,0,0, 0,0,1,0,0,6);
    stepCheck("stop_c5", 0,0,0, 0,0,1,0,0,6);
    stepCheck("stop_in", 0,0,0, 0,0,0,0,0,6);
    stepCheck("stop_hold", 0,0,0, 0,0,0,0,0,6);
    stepCheck("restart", 1,0,0, 1,1,1,0,0,6);
    // en low mid-period, back high before the end: no stop
    stepCheck("cancel_c1", 0,0,0, 1,0,1,0,0,6);
    stepCheck("cancel_c2", 0,0,0, 1,0,1,0,0,6);
    stepCheck("cancel_c3", 0,0,0, 0,0,1,0,0,6);
    stepCheck("cancel_c4", 0,0,0, 0,0,1,0,0,6);
    stepCheck("cancel_c5", 0,0,0, 0,0,1,0,0,6);
    stepCheck("cancel_wrap", 1,0,0, 1,1,1,0,0,6);

    // pending ratio plus en=0 at the boundary: applied and stopped together
    stepCheck("pstop_c1", 1,1,3, 1,0,1,0,0,6);
    stepCheck("pstop_c2", 1,1,3, 1,0,1,0,0,6);
    stepCheck("pstop_c3", 1,1,3, 0,0,1,0,0,6);
    stepCheck("pstop_c4", 1,1,3, 0,0,1,0,0,6);
    stepCheck("pstop_c5", 1,1,3, 0,0,1,0,0,6);
    stepCheck("pstop_end", 0,1,3, 0,0,0,1,0,3);
    stepCheck("pstop_idle", 0,0,0, 0,0,0,0,0,3);

    // en rising with a valid request in STOP: first period uses the new ratio
    stepCheck("simul_c0", 1,1,4, 1,1,1,1,0,4);
    stepCheck("simul_c1", 1,0,0, 1,0,1,0,0,4);
    stepCheck("simul_c2", 1,0,0, 0,0,1,0,0,4);
    stepCheck("simul_c3", 1,0,0, 0,0,1,0,0,4);
    stepCheck("simul_wrap", 1,0,0, 1,1,1,0,0,4);

    // N=8, then a pending request killed by async reset
    stepCheck("n8_a", 1,1,8, 1,0,1,0,0,4);
    stepCheck("n8_b", 1,1,8, 0,0,1,0,0,4);
    stepCheck("n8_c", 1,1,8, 0,0,1,0,0,4);
    stepCheck("n8_d", 1,1,8, 1,1,1,1,0,8);
    stepCheck("n8_c1", 1,0,0, 1,0,1,0,0,8);
    stepCheck("n8_pend", 1,1,4, 1,0,1,0,0,8);
    resetn = 1'b0;
    #1;
    checkOutput("async_reset", 0, 0, 0, 0, 0, 8'd2);
    en          = 1'b0;
    bus.div_req = 1'b0;
    bus.div_val = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge in);
      checkOutput($sformatf("reset_hold%0d", i), 0, 0, 0, 0, 0, 8'd2);
    end
    resetn = 1'b1;
    for (int i = 0; i < 10; i++)
      stepCheck($sformatf("post_reset%0d", i), 0,0,0, 0,0,0,0,0,2);
    stepCheck("post_reset_run", 1,0,0, 1,1,1,0,0,2);
    stepCheck("post_reset_c1", 1,0,0, 0,0,1,0,0,2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
Runtime-programmable clock-divider controller. It generates a divided clock `out` from the source clock `in` with a divide ratio that can be changed while running. Ratio changes are accepted over a req/ack handshake and applied only at period boundaries, so `out` never produces a runt pulse. It also provides glitch-free start/stop, and sits beside the fixed clk_div2/clk_div3 dividers for cases where the ratio must change at runtime.

Parameters:
W, 8, width of the divide-ratio field and the internal period counter.
DEF_DIV, 2, ratio loaded at reset; must satisfy 2 <= DEF_DIV <= 2^W-1.

Ports:
in        input   1  source clock; all logic runs on the rising edge.
resetn    input   1  asynchronous active-low reset.
en        input   1  run enable (level).
div_req   input   1  ratio-change request; held high until div_ack.
div_val   input   W  requested ratio; stable while div_req is high.
div_ack   output  1  one-cycle pulse: request completed.
div_err   output  1  one-cycle pulse with div_ack: request rejected.
out       output  1  divided clock, registered.
tick      output  1  one-cycle pulse on the first cycle of each `out` period.
running   output  1  high while in RUN.
cur_div   output  W  ratio currently in effect.

Behaviour:
- Reset is asynchronous, active-low. On reset: out=0, tick=0, running=0, div_ack=0, div_err=0, cur_div=DEF_DIV, counter=0, pending flag cleared, state STOP. Asserting reset mid-operation forces these values immediately. A pending request is discarded and never acked.
- Let N=cur_div and H=N-floor(N/2) (high phase rounds up). A period is cycles c=0..N-1. out=1 for c<H and 0 for c>=H. tick=1 at c=0. All outputs are registered.
- STOP state: out=0, running=0. When en=1 is sampled at edge k, the cycle after edge k is c=0 of RUN (out=1, tick=1, running=1). Start latency is 1 clock.
- RUN state: the counter runs 0..N-1 and wraps. The period end is c=N-1.
  - If en=0 is sampled at c=N-1, go to STOP. out stays 0 because it is already in the low phase.
  - Deasserting en mid-period never truncates the period. Reasserting en before c=N-1 cancels the stop.
- Handshake:
  - A request is sampled on an edge where div_req=1, nothing is pending, and div_ack is not asserted in that cycle.
  - If div_val<2: on the next cycle div_ack=1 and div_err=1 for one cycle. There is no other effect.
  - Else, in STOP: cur_div<=div_val and div_ack pulses on the next cycle.
  - Else, in RUN: div_val is latched into the pending register and the pending flag is set. At c=N-1, cur_div<=pending and the flag clears. The next cycle is c=0 of a period using the new N, and div_ack pulses coincident with its tick.
  - The requester drops div_req on the cycle after div_ack. div_req still high in the ack cycle is not resampled.
- Simultaneous events:
  - Pending ratio plus en=0 at c=N-1: the ratio is applied (cur_div updated, div_ack pulses next cycle) and the state goes to STOP.
  - en rising and a valid request in the same STOP cycle: the new ratio is used for the first period.
  - A request latched at c=N-1 itself is not applied at that boundary. It waits for the following boundary.
- Maximum ratio 2^W-1. The counter is W bits and never overflows.

Test Plan:
1. DEF_DIV=2: release reset, en=1 -> out toggles every cycle (1,0,1,0…), tick on every high, running=1 one cycle after en.
2. In STOP, request div_val=5, then en=1 -> ack 1 cycle after request. out = 3 high, 2 low, repeating. cur_div=5.
3. Running N=4, request div_val=3 at c=1 -> remaining period unchanged (c=2,3 low). The next period is 2 high, 1 low. div_ack is coincident with that period's tick.
4. Request div_val=1 and separately div_val=0 -> div_ack and div_err pulse together. cur_div unchanged and out uninterrupted.
5. N=6, drop en at c=1 -> period completes (3 high, 3 low), then out=0 and running=0. Reassert en -> tick and out=1 after 1 cycle.
6. N=8, request div_val=4 pending, assert resetn=0 at c=2 -> out=0 and cur_div=DEF_DIV immediately. No div_ack ever issued.
